// File: rtl/axi_dac_jesd204_pkg.sv
// Shared types and derived-parameter helpers for the JESD204 TX transport framer.
package axi_dac_jesd204_pkg;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_PN7    = 2'd3
  } mode_e;

  localparam logic [6:0] PN7_SEED = 7'h7F;

  // F: octets per lane per frame
  function automatic int calc_f(input int lanes, input int chans);
    return (2 * chans) / lanes;
  endfunction

  // S: samples per channel per beat
  function automatic int calc_s(input int opb, input int f);
    return opb / f;
  endfunction

  function automatic int calc_bpm(input int k, input int s);
    return k / s;
  endfunction

  function automatic int map_lane(input int g, input int f);
    return g / f;
  endfunction

  function automatic int map_pos(input int s, input int g, input int f);
    return s * f + g % f;
  endfunction

  // x^7 + x^6 + 1, output taken from bit 6 before the shift
  function automatic logic [6:0] pn7_step(input logic [6:0] st);
    return {st[5:0], st[6] ^ st[5]};
  endfunction

endpackage

// File: rtl/axi_dac_jesd204_framer_if.sv
// Valid/ready beat stream used on both the DAC side and the link side of the framer.
interface axi_dac_jesd204_framer_if #(
  parameter int DW = 256
) ();
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axi_dac_jesd204_lane_map.sv
// Combinational octet remap from channel-major samples to JESD lane octets.
module axi_dac_jesd204_lane_map
  import axi_dac_jesd204_pkg::*;
#(
  parameter int NUM_LANES       = 8,
  parameter int NUM_CHANNELS    = 4,
  parameter int OCTETS_PER_BEAT = 4
) (
  input  logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] src,
  output logic [NUM_LANES*8*OCTETS_PER_BEAT-1:0] lanes
);

  localparam int F = calc_f(NUM_LANES, NUM_CHANNELS);
  localparam int S = calc_s(OCTETS_PER_BEAT, F);
  localparam int LW = 8 * OCTETS_PER_BEAT;

  // every (channel, sample, byte) lands on exactly one lane octet, so the map is a permutation
  for (genvar m = 0; m < NUM_CHANNELS; m++) begin : g_ch
    for (genvar s = 0; s < S; s++) begin : g_smp
      for (genvar b = 0; b < 2; b++) begin : g_oct
        localparam int G    = 2 * m + b;
        localparam int LANE = map_lane(G, F);
        localparam int POS  = map_pos(s, G, F);
        assign lanes[LANE*LW + POS*8 +: 8] = src[(m*S + s)*16 + (1 - b)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_dac_jesd204_framer.sv
// JESD204 TX transport framer: source select (stage 1), lane map (stage 2), status.
// Optional PN7 generator enabled by defining DAC_JESD_FRAMER_PN7_EN.
module axi_dac_jesd204_framer
  import axi_dac_jesd204_pkg::*;
#(
  parameter int NUM_LANES             = 8,
  parameter int NUM_CHANNELS          = 4,
  parameter int OCTETS_PER_BEAT       = 4,
  parameter int FRAMES_PER_MULTIFRAME = 32
) (
  input  logic                     tx_clk,
  input  logic                     dac_rst,
  axi_dac_jesd204_framer_if.slave  dac,
  axi_dac_jesd204_framer_if.master tx,
  input  logic [1:0]               cfg_mode,
  output logic [1:0]               cfg_mode_active,
  output logic                     status_underflow,
  output logic [15:0]              status_underflow_cnt,
  input  logic                     status_clr
);

  localparam int F   = calc_f(NUM_LANES, NUM_CHANNELS);
  localparam int S   = calc_s(OCTETS_PER_BEAT, F);
  localparam int BPM = calc_bpm(FRAMES_PER_MULTIFRAME, S);
  localparam int DW  = NUM_LANES * 8 * OCTETS_PER_BEAT;
  localparam int CW  = (BPM > 1) ? $clog2(BPM) : 1;
  localparam logic [CW-1:0] MF_LAST = CW'(BPM - 1);

  mode_e          mode_r;
  mode_e          mode_next_s;
  logic           mode_load_s;
  logic           mode_entry_s;
  logic           underflow_s;
  logic [CW-1:0]  mf_cnt_r;
  logic [15:0]    ramp_base_r;
  logic [DW-1:0]  ramp_s;
  logic [DW-1:0]  pn_s;
  logic [DW-1:0]  src_s;
  logic [DW-1:0]  src_r;
  logic [DW-1:0]  map_s;
  logic           v1_r;

  assign dac.ready       = tx.ready;
  assign cfg_mode_active = mode_r;
  assign mode_entry_s    = mode_load_s && (mode_next_s != mode_r);
  assign underflow_s     = tx.ready && !dac.valid && (mode_r == MODE_NORMAL);

  // Mode is reloaded while the link idles or on the last beat of a multiframe
  always_comb begin
    mode_load_s = 1'b0;
    mode_next_s = mode_r;
    if (!tx.ready || (mf_cnt_r == MF_LAST)) begin
      mode_load_s = 1'b1;
      mode_next_s = mode_e'(cfg_mode);
    end else begin
      mode_load_s = 1'b0;
      mode_next_s = mode_r;
    end
  end

  // Ramp samples: identical on every channel, sample s = base + s
  always_comb begin
    ramp_s = '0;
    for (int m = 0; m < NUM_CHANNELS; m++) begin
      for (int s = 0; s < S; s++) begin
        ramp_s[(m*S + s)*16 +: 16] = ramp_base_r + 16'(s);
      end
    end
  end

`ifdef DAC_JESD_FRAMER_PN7_EN
  logic [6:0] pn_r;
  logic [6:0] pn_adv_s;

  // Unroll S*16 PN7 steps; first bit of the beat is the MSB of sample 0
  always_comb begin
    logic [6:0]  st;
    logic [15:0] val;
    pn_s = '0;
    st   = pn_r;
    val  = 16'h0000;
    for (int s = 0; s < S; s++) begin
      for (int j = 0; j < 16; j++) begin
        val[15 - j] = st[6];
        st = pn7_step(st);
      end
      for (int m = 0; m < NUM_CHANNELS; m++) begin
        pn_s[(m*S + s)*16 +: 16] = val;
      end
    end
    pn_adv_s = st;
  end

  // LFSR state: reseeded on entry to PN7, advanced per consumed beat
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      pn_r <= PN7_SEED;
    end else if (mode_entry_s && (mode_next_s == MODE_PN7)) begin
      pn_r <= PN7_SEED;
    end else if (tx.ready && (mode_r == MODE_PN7)) begin
      pn_r <= pn_adv_s;
    end else begin
      pn_r <= pn_r;
    end
  end
`else
  assign pn_s = '0;
`endif

  // Stage 1 source select; zeros whenever the link is not consuming
  always_comb begin
    src_s = '0;
    if (tx.ready) begin
      case (mode_r)
        MODE_NORMAL: src_s = dac.valid ? dac.data : '0;
        MODE_ZERO:   src_s = '0;
        MODE_RAMP:   src_s = ramp_s;
        MODE_PN7:    src_s = pn_s;
        default:     src_s = '0;
      endcase
    end else begin
      src_s = '0;
    end
  end

  // Multiframe counter, active mode and ramp base
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      mode_r      <= MODE_NORMAL;
      mf_cnt_r    <= '0;
      ramp_base_r <= 16'h0000;
    end else begin
      mode_r <= mode_next_s;
      if (!tx.ready || (mf_cnt_r == MF_LAST)) begin
        mf_cnt_r <= '0;
      end else begin
        mf_cnt_r <= mf_cnt_r + 1'b1;
      end
      if (mode_entry_s && (mode_next_s == MODE_RAMP)) begin
        ramp_base_r <= 16'h0000;
      end else if (tx.ready && (mode_r == MODE_RAMP)) begin
        ramp_base_r <= ramp_base_r + 16'(S);
      end else begin
        ramp_base_r <= ramp_base_r;
      end
    end
  end

  axi_dac_jesd204_lane_map #(
    .NUM_LANES       (NUM_LANES),
    .NUM_CHANNELS    (NUM_CHANNELS),
    .OCTETS_PER_BEAT (OCTETS_PER_BEAT)
  ) u_lane_map (
    .src   (src_r),
    .lanes (map_s)
  );

  // Two-stage data pipeline: raw beat, then lane-mapped beat
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      src_r    <= '0;
      v1_r     <= 1'b0;
      tx.data  <= '0;
      tx.valid <= 1'b0;
    end else begin
      src_r    <= src_s;
      v1_r     <= tx.ready;
      tx.data  <= map_s;
      tx.valid <= v1_r;
    end
  end

  // Sticky underflow flag and saturating count; a clear beats a coincident underflow
  always_ff @(posedge tx_clk) begin
    if (dac_rst) begin
      status_underflow     <= 1'b0;
      status_underflow_cnt <= 16'h0000;
    end else if (status_clr) begin
      status_underflow     <= 1'b0;
      status_underflow_cnt <= 16'h0000;
    end else if (underflow_s) begin
      status_underflow     <= 1'b1;
      status_underflow_cnt <= (status_underflow_cnt == 16'hFFFF) ?
                              status_underflow_cnt : status_underflow_cnt + 16'h0001;
    end else begin
      status_underflow     <= status_underflow;
      status_underflow_cnt <= status_underflow_cnt;
    end
  end

endmodule
